rf68000_ram_arbiter: RTL

Round-robin arbiter that shares one node's local dual-use RAM port between up to NPORT Wishbone-classic requesters (CPU data, CPU instruction, NIC, DMA). It sequences each granted access into the RAM's enable/write-enable/address/data pins, waits out the RAM read latency, returns read data and acknowledges the requester. It sits between the node's bus masters and the local block RAM, replacing fixed-priority sharing with fair, lockable arbitration.

---
 rtl/rf68000_ram_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rf68000_ram_arbiter.sv
// rf68000_ram_arbiter: lockable round-robin arbiter that shares one local RAM port
// between NPORT Wishbone-classic requesters and waits out the RAM read latency.
module rf68000_ram_arbiter #(
    parameter int NPORT = 4,
    parameter int RLAT  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NPORT-1:0]      req_cyc,
    input  logic [NPORT-1:0]      req_stb,
    input  logic [NPORT-1:0]      req_we,
    input  logic [4*NPORT-1:0]    req_sel,
    input  logic [32*NPORT-1:0]   req_adr,
    input  logic [32*NPORT-1:0]   req_dato,
    output logic [NPORT-1:0]      req_ack,
    output logic [31:0]           req_dati,
    output logic [NPORT-1:0]      grant,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_adr,
    output logic [31:0]           ram_dati,
    input  logic [31:0]           ram_dato
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(RLAT + 1);
    localparam logic [NPORT-1:0] ONE_P = {{(NPORT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t           state_r, state_nx_s;
    logic [PW-1:0]    ptr_r, ptr_nx_s, owner_r, owner_nx_s;
    logic [PW-1:0]    win_s, iss_port_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic             wr_r, wr_nx_s;
    logic             win_vld_s, issue_s, release_s, own_cyc_s, own_stb_s;
    logic [NPORT-1:0] cand_s, own_1h_s, ack_nx_s, grant_nx_s;
    logic [31:0]      dati_nx_s, ram_adr_nx_s, ram_dati_nx_s;
    logic             ram_en_nx_s;
    logic [3:0]       ram_we_nx_s;
    logic [3:0]       sel_a_s [NPORT];
    logic [31:0]      adr_a_s [NPORT];
    logic [31:0]      dat_a_s [NPORT];

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int sum_v;
        sum_v = int'(base) + off;
        return (sum_v >= NPORT) ? PW'(sum_v - NPORT) : PW'(sum_v);
    endfunction

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign sel_a_s[g] = req_sel[4*g +: 4];
        assign adr_a_s[g] = req_adr[32*g +: 32];
        assign dat_a_s[g] = req_dato[32*g +: 32];
    end

    assign cand_s     = req_cyc & req_stb;
    assign own_cyc_s  = req_cyc[owner_r];
    assign own_stb_s  = req_stb[owner_r];
    assign own_1h_s   = ONE_P << owner_r;
    assign iss_port_s = (state_r == ST_IDLE) ? win_s : owner_r;

    // Lock re-issue only listens to the owner; everyone else waits for release.
    assign issue_s   = ((state_r == ST_IDLE) && win_vld_s) ||
                       ((state_r == ST_LOCK) && own_cyc_s && own_stb_s);
    assign release_s = (((state_r == ST_ACCESS) || (state_r == ST_LOCK)) && !own_cyc_s) ||
                       ((state_r == ST_ACK) && !own_stb_s && !own_cyc_s);

    // Round-robin search: nearest candidate at or above the pointer wins.
    always_comb begin
        win_vld_s = 1'b0;
        win_s     = {PW{1'b0}};
        for (int i = NPORT - 1; i >= 0; i--) begin
            win_vld_s = win_vld_s | cand_s[wrap_add(ptr_r, i)];
            win_s     = cand_s[wrap_add(ptr_r, i)] ? wrap_add(ptr_r, i) : win_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = issue_s ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (release_s) begin
                    state_nx_s = ST_IDLE;
                end else if (wr_r || (cnt_r == {CW{1'b0}})) begin
                    state_nx_s = ST_ACK;
                end else begin
                    state_nx_s = ST_ACCESS;
                end
            end
            ST_ACK: begin
                if (own_stb_s) begin
                    state_nx_s = ST_ACK;
                end else if (own_cyc_s) begin
                    state_nx_s = ST_LOCK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (release_s) begin
                    state_nx_s = ST_IDLE;
                end else if (issue_s) begin
                    state_nx_s = ST_ACCESS;
                end else begin
                    state_nx_s = ST_LOCK;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; ram_we defaults low so a write pulse lasts one clock.
    always_comb begin
        ack_nx_s      = req_ack;
        dati_nx_s     = req_dati;
        grant_nx_s    = grant;
        ram_en_nx_s   = ram_en;
        ram_we_nx_s   = 4'b0000;
        ram_adr_nx_s  = ram_adr;
        ram_dati_nx_s = ram_dati;
        cnt_nx_s      = cnt_r;
        ptr_nx_s      = ptr_r;
        owner_nx_s    = owner_r;
        wr_nx_s       = wr_r;
        if (issue_s) begin
            grant_nx_s    = ONE_P << iss_port_s;
            owner_nx_s    = iss_port_s;
            ram_en_nx_s   = 1'b1;
            ram_adr_nx_s  = adr_a_s[iss_port_s];
            ram_dati_nx_s = dat_a_s[iss_port_s];
            ram_we_nx_s   = req_we[iss_port_s] ? sel_a_s[iss_port_s] : 4'b0000;
            wr_nx_s       = req_we[iss_port_s];
            cnt_nx_s      = CW'(RLAT);
        end else if (release_s) begin
            grant_nx_s  = {NPORT{1'b0}};
            ack_nx_s    = {NPORT{1'b0}};
            ram_en_nx_s = 1'b0;
            ptr_nx_s    = wrap_add(owner_r, 1);
        end else begin
            case (state_r)
                ST_ACCESS: begin
                    if (wr_r) begin
                        ack_nx_s = own_1h_s;
                    end else if (cnt_r == {CW{1'b0}}) begin
                        ack_nx_s  = own_1h_s;
                        dati_nx_s = ram_dato;
                    end else begin
                        cnt_nx_s = cnt_r - CW'(1);
                    end
                end
                ST_ACK: begin
                    if (!own_stb_s) begin
                        ack_nx_s    = {NPORT{1'b0}};
                        ram_en_nx_s = 1'b0;
                    end else begin
                        ack_nx_s = req_ack;
                    end
                end
                default: ack_nx_s = req_ack;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {PW{1'b0}};
            owner_r  <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            wr_r     <= 1'b0;
            req_ack  <= {NPORT{1'b0}};
            req_dati <= 32'h0000_0000;
            grant    <= {NPORT{1'b0}};
            ram_en   <= 1'b0;
            ram_we   <= 4'b0000;
            ram_adr  <= 32'h0000_0000;
            ram_dati <= 32'h0000_0000;
        end else begin
            state_r  <= state_nx_s;
            ptr_r    <= ptr_nx_s;
            owner_r  <= owner_nx_s;
            cnt_r    <= cnt_nx_s;
            wr_r     <= wr_nx_s;
            req_ack  <= ack_nx_s;
            req_dati <= dati_nx_s;
            grant    <= grant_nx_s;
            ram_en   <= ram_en_nx_s;
            ram_we   <= ram_we_nx_s;
            ram_adr  <= ram_adr_nx_s;
            ram_dati <= ram_dati_nx_s;
        end
    end

endmodule
